// File: rtl/lcp_pkg.sv
// rtl/lcp_pkg.sv - shared types, encodings and reset table for logic_chain_puzzle
//
// Purpose: op encodings, key codes, FSM state type, LED patterns, the
// initial operand byte table and small helper functions used by the
// logic_chain_puzzle top and its lockout timer.
// Ports: none (package).
package lcp_pkg;

  // Stage operators, in the order a key press advances them.
  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_XNOR = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_EVAL = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOCK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] KEY_SUBMIT = 4'd0;
  localparam logic [3:0] KEY_STAR   = 4'd10;
  localparam logic [3:0] KEY_HASH   = 4'd11;

  localparam logic [7:0] LED_MODE0 = 8'hFF;
  localparam logic [7:0] LED_MODE1 = 8'h00;
  localparam logic [7:0] LED_DONE  = 8'h0F;
  localparam logic [7:0] LED_LOCK  = 8'hAA;

  // Entry i is the reset byte of nums[i]; entry 0 sits in the low byte.
  localparam logic [8:0][7:0] INIT_BYTES = {
    8'hAA, 8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12
  };

  // Reset operand replicated to 16 bits; callers keep the low W bits.
  function automatic logic [15:0] init_num(input logic [3:0] idx);
    return {INIT_BYTES[idx], INIT_BYTES[idx]};
  endfunction

  function automatic logic [15:0] apply_op(input op_t op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic op_t next_op(input op_t op);
    return op_t'(op + 2'd1);
  endfunction

endpackage

// File: rtl/lcp_lock_timer.sv
// rtl/lcp_lock_timer.sv - lockout down-counter for logic_chain_puzzle
//
// Purpose: after load, counts LOCK_CYCLES cycles of count=1 and pulses
// expire during the last of them, so the owner leaves its lock state after
// exactly LOCK_CYCLES cycles.
// Ports:
//   clk     in  clock
//   rst_n   in  async active-low reset
//   load    in  (re)start the lockout period
//   count   in  high while the owner is locked
//   expire  out high in the final locked cycle
module lcp_lock_timer #(
  parameter int LOCK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

  logic [CW-1:0] cnt;

  // load presets LOCK_CYCLES-1 so the values LOCK_CYCLES-1..0 span the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LOCK_CYCLES - 1);
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = count && !load && (cnt == '0);

endmodule

// File: rtl/logic_chain_puzzle.sv
// rtl/logic_chain_puzzle.sv - chained bitwise-logic puzzle with keypad editing
//
// Purpose: holds N_OPS+1 operands and N_OPS operators, folds them one stage
// per cycle under control of the dip switches, lets the keypad invert
// operands / rotate operators, and checks the result against TARGET.
// Optional feature: define LOGIC_CHAIN_LOCKOUT_EN to lock the keypad for
// LOCK_CYCLES cycles after MAX_FAIL failed submits.
// Ports:
//   clk        in   clock
//   rst_n      in   async active-low reset
//   enable     in   gates key handling and the result pulses
//   dip_sw     in   stage k active when bit k = 1
//   key_valid  in   one-cycle key strobe
//   key_value  in   0 submit, 1..9 digit, 10 '*', 11 '#'
//   seg_data   out  eight 4-bit display digits
//   led_out    out  mode / status indicator
//   busy       out  evaluation in progress
//   clear, correct, fail  out  one-cycle result pulses
module logic_chain_puzzle
  import lcp_pkg::*;
#(
  parameter int            N_OPS       = 8,
  parameter int            W           = 8,
  parameter logic [W-1:0]  TARGET      = {W{1'b1}},
  parameter int            MAX_FAIL    = 3,
  parameter int            LOCK_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_OPS-1:0] dip_sw,
  input  logic             key_valid,
  input  logic [3:0]       key_value,
  output logic [31:0]      seg_data,
  output logic [7:0]       led_out,
  output logic             busy,
  output logic             clear,
  output logic             correct,
  output logic             fail
);

  state_t           state;
  logic [3:0]       stage;
  logic [W-1:0]     nums [N_OPS+1];
  op_t              ops  [N_OPS];
  logic [W-1:0]     acc;
  logic [W-1:0]     result;
  logic [N_OPS-1:0] dip_q;
  logic             edit_mode;
  logic [7:0]       led_q;
  logic             clear_q;
  logic             correct_q;
  logic             fail_q;

  logic             dip_chg;
  logic             key_ok;
  logic             key_digit;
  logic             fail_key;
  logic [W-1:0]     acc_in;
  logic [W-1:0]     acc_next;
  logic             stage_dip;
  op_t              stage_op;
  logic [W-1:0]     stage_num;

  assign dip_chg   = (dip_sw != dip_q);
  assign key_ok    = enable && key_valid && (state == ST_IDLE);
  assign key_digit = (key_value >= 4'd1) && (key_value <= 4'(N_OPS));
  assign fail_key  = key_ok && (key_value == KEY_SUBMIT) && (result != TARGET);

  // Stage 0 seeds the accumulator from nums[0] rather than the stale acc.
  always_comb begin
    acc_in    = (stage == 4'd0) ? nums[0] : acc;
    stage_dip = 1'b0;
    stage_op  = OP_AND;
    stage_num = '0;
    for (int k = 0; k < N_OPS; k++) begin
      if (stage == 4'(k)) begin
        stage_dip = dip_q[k];
        stage_op  = ops[k];
        stage_num = nums[k+1];
      end
    end
    acc_next = stage_dip ? W'(apply_op(stage_op, 16'(acc_in), 16'(stage_num)))
                         : acc_in;
  end

`ifdef LOGIC_CHAIN_LOCKOUT_EN
  localparam int FW = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;

  logic [FW-1:0] fail_cnt;
  logic          lock_load;
  logic          lock_expire;

  // The fail that brings fail_cnt up to MAX_FAIL starts the lockout.
  assign lock_load = fail_key && (fail_cnt == FW'(MAX_FAIL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt <= '0;
    end else if ((state == ST_LOCK) && lock_expire) begin
      fail_cnt <= '0;
    end else if (fail_key) begin
      fail_cnt <= fail_cnt + 1'b1;
    end
  end

  lcp_lock_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lock_load),
    .count  (state == ST_LOCK),
    .expire (lock_expire)
  );
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = (MAX_FAIL > 0) && (LOCK_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EVAL;
      stage     <= 4'd0;
      acc       <= '0;
      result    <= '0;
      dip_q     <= '0;
      edit_mode <= 1'b0;
      led_q     <= LED_MODE0;
      clear_q   <= 1'b0;
      correct_q <= 1'b0;
      fail_q    <= 1'b0;
      for (int i = 0; i <= N_OPS; i++) nums[i] <= W'(init_num(4'(i)));
      for (int i = 0; i < N_OPS; i++)  ops[i]  <= OP_AND;
    end else begin
      clear_q   <= 1'b0;
      correct_q <= 1'b0;
      fail_q    <= 1'b0;
      // dip_q freezes while locked/done so a change made then is seen on return to IDLE.
      if ((state == ST_IDLE) || (state == ST_EVAL)) dip_q <= dip_sw;

      case (state)
        ST_EVAL: begin
          if (dip_chg) begin
            stage <= 4'd0;
          end else begin
            acc <= acc_next;
            if (stage == 4'(N_OPS - 1)) begin
              result <= acc_next;
              stage  <= 4'd0;
              state  <= ST_IDLE;
            end else begin
              stage <= stage + 4'd1;
            end
          end
        end

        ST_IDLE: begin
          if (dip_chg) begin
            state <= ST_EVAL;
            stage <= 4'd0;
          end
          // Key outcomes are written after the dip check so they take priority.
          if (key_ok) begin
            case (key_value)
              KEY_SUBMIT: begin
                edit_mode <= 1'b0;
                if (result == TARGET) begin
                  clear_q   <= 1'b1;
                  correct_q <= 1'b1;
                  state     <= ST_DONE;
                  led_q     <= LED_DONE;
                end else begin
                  fail_q <= 1'b1;
                  led_q  <= LED_MODE0;
`ifdef LOGIC_CHAIN_LOCKOUT_EN
                  if (lock_load) begin
                    state <= ST_LOCK;
                    led_q <= LED_LOCK;
                  end
`endif
                end
              end
              KEY_STAR: begin
                edit_mode <= ~edit_mode;
                led_q     <= edit_mode ? LED_MODE0 : LED_MODE1;
              end
              KEY_HASH: begin
                for (int i = 0; i <= N_OPS; i++) nums[i] <= W'(init_num(4'(i)));
                for (int i = 0; i < N_OPS; i++)  ops[i]  <= OP_AND;
                edit_mode <= 1'b0;
                led_q     <= LED_MODE0;
                state     <= ST_EVAL;
                stage     <= 4'd0;
              end
              default: begin
                if (key_digit) begin
                  for (int k = 0; k < N_OPS; k++) begin
                    if (key_value == 4'(k + 1)) begin
                      if (!edit_mode) nums[k] <= ~nums[k];
                      else            ops[k]  <= next_op(ops[k]);
                    end
                  end
                  state <= ST_EVAL;
                  stage <= 4'd0;
                end
              end
            endcase
          end
        end

`ifdef LOGIC_CHAIN_LOCKOUT_EN
        ST_LOCK: begin
          if (lock_expire) begin
            state <= ST_IDLE;
            led_q <= LED_MODE0;
          end
        end
`endif

        ST_DONE: begin
          led_q <= LED_DONE;
        end

        default: begin
          state <= ST_IDLE;
          led_q <= LED_MODE0;
        end
      endcase
    end
  end

  // Narrow results show one bit per digit; wide results show plain hex.
  generate
    if (W <= 8) begin : g_bit_digits
      for (genvar i = 0; i < 8; i++) begin : g_digit
        if (i < W) begin : g_live
          assign seg_data[4*i +: 4] = {3'b000, result[i]};
        end else begin : g_blank
          assign seg_data[4*i +: 4] = 4'h0;
        end
      end
    end else begin : g_hex
      assign seg_data = 32'(result);
    end
  endgenerate

  assign led_out = led_q;
  assign busy    = (state == ST_EVAL);
  assign clear   = clear_q   & enable;
  assign correct = correct_q & enable;
  assign fail    = fail_q    & enable;

endmodule
